// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream instruction memory loader; optional checksum via LOADER_CHECKSUM_EN
module imem_loader #(
  parameter int DEPTH_WORDS = 256,
  parameter int CNT_W       = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] word_count,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  output logic             rx_ready,
  output logic             imem_we,
  output logic [31:0]      imem_addr,
  output logic [31:0]      imem_wdata,
  output logic             core_hold,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd4
  } state_t;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] word_idx_q, word_idx_d;
  logic [CNT_W-1:0] next_idx;
  logic [1:0]       byte_idx_q, byte_idx_d;
  // Only the low three bytes are buffered; the fourth goes straight into imem_wdata.
  logic [23:0]      word_q, word_d;
  logic             rx_ready_q, rx_ready_d;
  logic             imem_we_q, imem_we_d;
  logic [31:0]      imem_addr_q, imem_addr_d;
  logic [31:0]      imem_wdata_q, imem_wdata_d;
  logic             core_hold_q, core_hold_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             rx_fire;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]       sum_q, sum_d;
`endif

  assign rx_fire  = rx_valid && rx_ready_q;
  assign next_idx = word_idx_q + ONE_C;

  // Next-state logic; every registered output is derived from the state being entered.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    word_idx_d   = word_idx_q;
    byte_idx_d   = byte_idx_q;
    word_d       = word_q;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    core_hold_d  = core_hold_q;
    done_d       = done_q;
    err_d        = err_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d        = sum_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          done_d      = 1'b0;
          err_d       = 1'b0;
          word_idx_d  = '0;
          byte_idx_d  = '0;
          core_hold_d = 1'b1;
          count_d     = word_count;
`ifdef LOADER_CHECKSUM_EN
          sum_d       = '0;
`endif
          if (word_count == '0) begin
            state_d = S_DONE;
          end else if (word_count > DEPTH_C) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else begin
            state_d = S_RECV;
          end
        end
      end
      S_RECV: begin
        if (rx_fire) begin
`ifdef LOADER_CHECKSUM_EN
          sum_d = sum_q + rx_data;
`endif
          byte_idx_d = byte_idx_q + 2'd1;
          case (byte_idx_q)
            2'd0:    word_d[7:0]   = rx_data;
            2'd1:    word_d[15:8]  = rx_data;
            2'd2:    word_d[23:16] = rx_data;
            default: begin
              state_d      = S_WRITE;
              imem_wdata_d = {rx_data, word_q};
              imem_addr_d  = {{(30-CNT_W){1'b0}}, word_idx_q, 2'b00};
            end
          endcase
        end
      end
      S_WRITE: begin
        word_idx_d = next_idx;
        if (next_idx == count_q) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_RECV;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (rx_fire) begin
          if (rx_data != (8'd0 - sum_q)) begin
            err_d = 1'b1;
          end
          state_d = S_DONE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_DONE) begin
      done_d      = 1'b1;
      core_hold_d = 1'b0;
    end
`ifdef LOADER_CHECKSUM_EN
    rx_ready_d = (state_d == S_RECV) || (state_d == S_CHECK);
    busy_d     = (state_d == S_RECV) || (state_d == S_WRITE) || (state_d == S_CHECK);
`else
    rx_ready_d = (state_d == S_RECV);
    busy_d     = (state_d == S_RECV) || (state_d == S_WRITE);
`endif
    imem_we_d = (state_d == S_WRITE);
  end

  // State and registered outputs; reset abandons any load in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      word_idx_q   <= '0;
      byte_idx_q   <= '0;
      word_q       <= '0;
      rx_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      core_hold_q  <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      word_idx_q   <= word_idx_d;
      byte_idx_q   <= byte_idx_d;
      word_q       <= word_d;
      rx_ready_q   <= rx_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      core_hold_q  <= core_hold_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q        <= sum_d;
`endif
    end
  end

  assign rx_ready   = rx_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign core_hold  = core_hold_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader with random byte streams
module tb_imem_loader;

  localparam int CNT_W = 9;

  logic             clk;
  logic             reset;
  logic             start;
  logic [CNT_W-1:0] word_count;
  logic             rx_valid;
  logic [7:0]       rx_data;
  logic             rx_ready;
  logic             imem_we;
  logic [31:0]      imem_addr;
  logic [31:0]      imem_wdata;
  logic             core_hold;
  logic             busy;
  logic             done;
  logic             err;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_writes = 0;
  logic [63:0] sb[$];
  logic [63:0] sb_e;
  logic [31:0] words_q[$];

  imem_loader #(.DEPTH_WORDS(256), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .word_count (word_count),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_hold  (core_hold),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe is matched against the oldest expected write.
  always @(negedge clk) begin
    if (reset && imem_we) begin
      n_writes++;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", imem_addr, imem_wdata);
      end else begin
        sb_e = sb.pop_front();
        check("write_addr", imem_addr, sb_e[63:32]);
        check("write_data", imem_wdata, sb_e[31:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input int c);
    start      = 1'b1;
    word_count = CNT_W'(c);
    tick();
    start      = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && t < 20) begin
      tick();
      t++;
    end
    if (!rx_ready) check("rx_ready_timeout", 32'(rx_ready), 32'd1);
    tick();
    rx_valid = 1'b0;
    rx_data  = $urandom_range(0, 255);
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done && t < 20) begin
      tick();
      t++;
    end
    check("done_seen", 32'(done), 32'd1);
  endtask

  // Reference: word i lands at byte address 4*i; checksum byte is the negated byte sum.
  task automatic run_load(input int n, input int stall_at, input int poke_at,
                          input int gap_max, input logic bad_ck);
    int         w0;
    logic [7:0] sum;
    logic [7:0] ck;
    logic [31:0] w;
    w0  = n_writes;
    sum = 8'd0;
    for (int i = 0; i < n; i++) sb.push_back({32'(i * 4), words_q[i]});
    start_load(n);
    for (int i = 0; i < n; i++) begin
      w = words_q[i];
      for (int k = 0; k < 4; k++) begin
        if (i * 4 + k == stall_at) begin
          for (int s = 0; s < 3; s++) begin
            tick();
            check("stall_rx_ready", 32'(rx_ready), 32'd1);
          end
        end
        if (i * 4 + k == poke_at) begin
          check("poke_busy", 32'(busy), 32'd1);
          start_load(1);
        end
        repeat ($urandom_range(0, gap_max)) tick();
        sum = sum + w[8*k +: 8];
        send_byte(w[8*k +: 8]);
      end
    end
    ck = 8'd0 - sum;
`ifdef LOADER_CHECKSUM_EN
    send_byte(bad_ck ? ~ck : ck);
`endif
    wait_done();
`ifdef LOADER_CHECKSUM_EN
    check("load_err", 32'(err), 32'(bad_ck));
`else
    check("load_err", 32'(err), 32'd0);
`endif
    check("load_core_hold", 32'(core_hold), 32'd0);
    check("load_busy", 32'(busy), 32'd0);
    check("load_rx_ready", 32'(rx_ready), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("write_count", 32'(n_writes - w0), 32'(n));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    check("rst_core_hold", 32'(core_hold), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rx_ready", 32'(rx_ready), 32'd0);
    check("rst_imem_we", 32'(imem_we), 32'd0);
    check("rst_imem_addr", imem_addr, 32'd0);
    check("rst_imem_wdata", imem_wdata, 32'd0);
  endtask

  initial begin
    int w0;
    int n;
    reset      = 1'b0;
    start      = 1'b0;
    word_count = '0;
    rx_valid   = 1'b0;
    rx_data    = 8'd0;
    tick();
    do_reset();

    // Two-instruction reference load
    words_q = {32'h0000_0013, 32'h0010_0093};
    run_load(2, -1, -1, 0, 1'b0);

    // Three-cycle stall between byte 2 and byte 3
    words_q = {32'hDEAD_BEEF};
    run_load(1, 2, -1, 0, 1'b0);

    // Zero-length load
    w0 = n_writes;
    start_load(0);
    if (!done) tick();
    check("zero_done", 32'(done), 32'd1);
    check("zero_err", 32'(err), 32'd0);
    check("zero_core_hold", 32'(core_hold), 32'd0);
    repeat (3) tick();
    check("zero_writes", 32'(n_writes - w0), 32'd0);

    // Oversized load is rejected
    start_load(257);
    if (!done) tick();
    check("big_done", 32'(done), 32'd1);
    check("big_err", 32'(err), 32'd1);
    check("big_core_hold", 32'(core_hold), 32'd0);
    repeat (3) tick();
    check("big_writes", 32'(n_writes - w0), 32'd0);

    // Bytes presented outside a load are not consumed
    rx_valid = 1'b1;
    rx_data  = 8'hA5;
    repeat (4) tick();
    check("idle_rx_ready", 32'(rx_ready), 32'd0);
    rx_valid = 1'b0;
    check("idle_writes", 32'(n_writes - w0), 32'd0);

    // Reset mid-word abandons the load
    start_load(2);
    send_byte(8'h11);
    send_byte(8'h22);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("abort_core_hold", 32'(core_hold), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    repeat (6) tick();
    check("abort_writes", 32'(n_writes - w0), 32'd0);
    words_q = {32'h1234_5678};
    run_load(1, -1, -1, 1, 1'b0);

    // Start pulse mid-load is ignored
    words_q = {32'h0101_0101, 32'h0202_0202, 32'h0303_0303};
    run_load(3, -1, 6, 1, 1'b0);

    // Randomized loads with random inter-byte gaps
    for (int r = 0; r < 5; r++) begin
      n = $urandom_range(1, 6);
      words_q = {};
      for (int i = 0; i < n; i++) words_q.push_back($urandom);
      run_load(n, -1, -1, 2, 1'b0);
    end

    // Full-capacity load
    words_q = {};
    for (int i = 0; i < 256; i++) words_q.push_back($urandom);
    run_load(256, -1, -1, 0, 1'b0);

`ifdef LOADER_CHECKSUM_EN
    words_q = {32'h0403_0201};
    run_load(1, -1, -1, 0, 1'b0);
    run_load(1, -1, -1, 0, 1'b1);
`endif

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
